// File: rtl/fpmul_pkg.sv
// Shared constants and types for the two-requester FP multiplier arbiter.
package fpmul_pkg;

  localparam int W_DEF   = 32;
  localparam int LAT_DEF = 3;
  localparam int LAT_MAX = 8;

  // Owner-tag encoding carried down the tag pipeline
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic vld;
    logic own;
  } tag_t;

endpackage

// File: rtl/fpmul_opmux.sv
// W-wide 2:1 operand multiplexer assembled from 1-bit mux2 cells.
module fpmul_mux2 (
  input  logic i_d0,
  input  logic i_d1,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

module fpmul_opmux #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic         i_sel,
  output logic [W-1:0] o_y
);

  for (genvar g = 0; g < W; g++) begin : g_bit
    fpmul_mux2 u_cell (
      .i_d0  (i_d0[g]),
      .i_d1  (i_d1[g]),
      .i_sel (i_sel),
      .o_y   (o_y[g])
    );
  end

endmodule

// File: rtl/fpmul_arb2.sv
// Round-robin arbiter sharing one fixed-latency multiplier between two requesters.
// Optional per-requester grant counters when FPMUL_ARB2_STATS_EN is defined.
module fpmul_arb2
  import fpmul_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_v0,
  input  logic         i_v1,
  input  logic [W-1:0] i_a0,
  input  logic [W-1:0] i_b0,
  input  logic [W-1:0] i_a1,
  input  logic [W-1:0] i_b1,
  output logic         o_rdy0,
  output logic         o_rdy1,
  input  logic         i_hold,
  output logic         o_u_valid,
  output logic         o_u_sel,
  output logic [W-1:0] o_u_a,
  output logic [W-1:0] o_u_b,
  input  logic [W-1:0] i_u_res,
  output logic         o_r0_valid,
  output logic         o_r1_valid,
  output logic [W-1:0] o_r_data,
  output logic         o_busy
`ifdef FPMUL_ARB2_STATS_EN
  ,
  output logic [15:0]  o_gcnt0,
  output logic [15:0]  o_gcnt1
`endif
);

  if (LAT < 1 || LAT > LAT_MAX) begin : g_lat_chk
    $error("fpmul_arb2: LAT out of range");
  end

  logic r_ptr;
  logic r_usel;
  tag_t r_tag [LAT];

  logic w_rdy0;
  logic w_rdy1;
  logic w_u_valid;
  logic w_sel;
  logic w_busy;

  // Grant: sole requester wins; on a tie the one not granted last wins.
  // Reset also forces the grants low so nothing handshakes while held.
  always_comb begin
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    if (!i_rst && !i_hold) begin
      w_rdy0 = i_v0 && (!i_v1 || (r_ptr == REQ1));
      w_rdy1 = i_v1 && (!i_v0 || (r_ptr == REQ0));
    end
  end

  assign w_u_valid = w_rdy0 | w_rdy1;
  assign w_sel     = w_rdy1 ? REQ1 : (w_rdy0 ? REQ0 : r_usel);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr  <= REQ1;
      r_usel <= REQ0;
    end else begin
      r_usel <= w_sel;
      if (w_u_valid) begin
        r_ptr <= w_sel;
      end
    end
  end

  fpmul_opmux #(.W(W)) u_mux_a (
    .i_d0  (i_a0),
    .i_d1  (i_a1),
    .i_sel (w_sel),
    .o_y   (o_u_a)
  );

  fpmul_opmux #(.W(W)) u_mux_b (
    .i_d0  (i_b0),
    .i_d1  (i_b1),
    .i_sel (w_sel),
    .o_y   (o_u_b)
  );

  // Tag pipeline: the tag reaches the last stage in the cycle U_RES is valid
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{vld: w_u_valid, own: w_sel};
      for (int i = 1; i < LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      w_busy = w_busy | r_tag[i].vld;
    end
  end

  assign o_rdy0     = w_rdy0;
  assign o_rdy1     = w_rdy1;
  assign o_u_valid  = w_u_valid;
  assign o_u_sel    = w_sel;
  assign o_r0_valid = r_tag[LAT-1].vld && (r_tag[LAT-1].own == REQ0);
  assign o_r1_valid = r_tag[LAT-1].vld && (r_tag[LAT-1].own == REQ1);
  assign o_r_data   = i_u_res;
  assign o_busy     = w_busy;

`ifdef FPMUL_ARB2_STATS_EN
  logic [15:0] r_gcnt0;
  logic [15:0] r_gcnt1;

  // Saturating handshake counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else begin
      if (w_rdy0 && i_v0 && (r_gcnt0 != 16'hFFFF)) begin
        r_gcnt0 <= r_gcnt0 + 16'd1;
      end
      if (w_rdy1 && i_v1 && (r_gcnt1 != 16'hFFFF)) begin
        r_gcnt1 <= r_gcnt1 + 16'd1;
      end
    end
  end

  assign o_gcnt0 = r_gcnt0;
  assign o_gcnt1 = r_gcnt1;
`endif

endmodule

// File: tb/tb_fpmul_arb2.sv
// Scoreboard bench for fpmul_arb2 with a behavioural 3-cycle multiplier.
module tb_fpmul_arb2;

  localparam int W   = 32;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v0 = 1'b0, v1 = 1'b0, hold = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         rdy0, rdy1, u_valid, u_sel, r0_valid, r1_valid, busy;
  logic [W-1:0] u_a, u_b, u_res, r_data;
`ifdef FPMUL_ARB2_STATS_EN
  logic [15:0]  gcnt0, gcnt1;
`endif

  logic [W-1:0] exp0 = '0, exp1 = '0;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  typedef struct {
    logic         own;
    logic [W-1:0] data;
    int           cyc;
  } sb_t;
  sb_t sbq[$];

  always #5 clk = ~clk;

  fpmul_arb2 #(.W(W), .LAT(LAT)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_v0       (v0),
    .i_v1       (v1),
    .i_a0       (a0),
    .i_b0       (b0),
    .i_a1       (a1),
    .i_b1       (b1),
    .o_rdy0     (rdy0),
    .o_rdy1     (rdy1),
    .i_hold     (hold),
    .o_u_valid  (u_valid),
    .o_u_sel    (u_sel),
    .o_u_a      (u_a),
    .o_u_b      (u_b),
    .i_u_res    (u_res),
    .o_r0_valid (r0_valid),
    .o_r1_valid (r1_valid),
    .o_r_data   (r_data),
    .o_busy     (busy)
`ifdef FPMUL_ARB2_STATS_EN
    ,
    .o_gcnt0    (gcnt0),
    .o_gcnt1    (gcnt1)
`endif
  );

  // Truncating single-precision multiply for normal operands
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] ma, mb, p;
    int          e;
    logic [22:0] m;
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  logic [W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= u_valid ? fmul(u_a, u_b) : 32'h0;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign u_res = mpipe[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: retire results first, then record this cycle's handshakes
  always @(negedge clk) begin
    if (!rst) begin
      chk("one_grant", {31'd0, rdy0 & rdy1}, 32'd0);
      if (r0_valid || r1_valid) begin
        chk("one_result", {31'd0, r0_valid & r1_valid}, 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_result", {31'd0, r1_valid}, 32'hFFFF_FFFF);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("res_owner", {31'd0, r1_valid}, {31'd0, e.own});
          chk("res_data", r_data, e.data);
          chk("res_latency", 32'(cyc - e.cyc), 32'(LAT));
        end
      end
      if (v0 && rdy0) sbq.push_back('{own: 1'b0, data: exp0, cyc: cyc});
      if (v1 && rdy1) sbq.push_back('{own: 1'b1, data: exp1, cyc: cyc});
    end
  end

  task automatic drive(input logic nv0, input logic nv1, input logic nh);
    @(posedge clk);
    #1;
    v0   = nv0;
    v1   = nv1;
    hold = nh;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((busy || sbq.size() != 0) && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain_queue", 32'(sbq.size()), 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] ta0 [4] = '{32'h3F800000, 32'h0, 32'h3FC00000, 32'h0};
  logic [W-1:0] tb0 [4] = '{32'h40000000, 32'h0, 32'h40000000, 32'h0};
  logic [W-1:0] ta1 [4] = '{32'h0, 32'h40000000, 32'h0, 32'h40400000};
  logic [W-1:0] tb1 [4] = '{32'h0, 32'h40000000, 32'h0, 32'h3F000000};
  logic [W-1:0] te  [4] = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h3FC00000};

  initial begin
    int t_last;
    // Reset state with both requesters asserting
    v0 = 1'b1;
    v1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy0", {31'd0, rdy0}, 32'd0);
    chk("rst_rdy1", {31'd0, rdy1}, 32'd0);
    chk("rst_u_valid", {31'd0, u_valid}, 32'd0);
    chk("rst_u_sel", {31'd0, u_sel}, 32'd0);
    chk("rst_rvalid", {30'd0, r1_valid, r0_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v0  = 1'b0;
    v1  = 1'b0;

    // Alternating ties right after reset: 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      a0 = ta0[i]; b0 = tb0[i]; a1 = ta1[i]; b1 = tb1[i];
      exp0 = (i % 2 == 0) ? te[i] : 32'h0;
      exp1 = (i % 2 == 1) ? te[i] : 32'h0;
      @(negedge clk);
      chk("tie_rdy0", {31'd0, rdy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("tie_rdy1", {31'd0, rdy1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("tie_u_sel", {31'd0, u_sel}, 32'(i % 2));
    end
    drive(1'b0, 1'b0, 1'b0);
    drain();

    // Single requester 0: 1.0 * 2.0
    drive(1'b1, 1'b0, 1'b0);
    a0 = 32'h3F800000; b0 = 32'h40000000; exp0 = 32'h40000000;
    @(negedge clk);
    chk("single_rdy0", {31'd0, rdy0}, 32'd1);
    chk("single_u_valid", {31'd0, u_valid}, 32'd1);
    chk("single_u_sel", {31'd0, u_sel}, 32'd0);
    chk("single_u_a", u_a, 32'h3F800000);
    chk("single_u_b", u_b, 32'h40000000);
    drive(1'b0, 1'b0, 1'b0);
    drain();

    // Streaming with a two-cycle hold in the middle
    a0 = 32'h3F800000; b0 = 32'h40000000; exp0 = 32'h40000000;
    a1 = 32'h40000000; b1 = 32'h40000000; exp1 = 32'h40800000;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("hold_rdy", {30'd0, rdy1, rdy0}, 32'd0);
      chk("hold_u_valid", {31'd0, u_valid}, 32'd0);
    end
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_resume", {31'd0, u_valid}, 32'd1);
    t_last = cyc;
    drive(1'b0, 1'b0, 1'b0);
    while (cyc < t_last + LAT) @(negedge clk);
    chk("busy_last_stage", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    drain();

    // Reset with two operations in flight; leave PTR at 0 beforehand
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("postrst_tie", {30'd0, rdy1, rdy0}, 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    drain();

    // Random traffic with distinct operands per requester
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom), 1'($urandom), ($urandom_range(3) == 0));
      a0 = {1'($urandom), 8'(100 + $urandom_range(49)), 23'($urandom)};
      b0 = {1'($urandom), 8'(100 + $urandom_range(49)), 23'($urandom)};
      a1 = {1'($urandom), 8'(100 + $urandom_range(49)), 23'($urandom)};
      b1 = {1'($urandom), 8'(100 + $urandom_range(49)), 23'($urandom)};
      exp0 = fmul(a0, b0);
      exp1 = fmul(a1, b1);
    end
    drive(1'b0, 1'b0, 1'b0);
    drain();

`ifdef FPMUL_ARB2_STATS_EN
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("gcnt0_clr", {16'd0, gcnt0}, 32'd0);
    a0 = 32'h3F800000; b0 = 32'h40000000; exp0 = 32'h40000000;
    drive(1'b1, 1'b0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    v0 = 1'b0;
    @(negedge clk);
    chk("gcnt0_sat", {16'd0, gcnt0}, 32'h0000FFFF);
    chk("gcnt1_zero", {16'd0, gcnt1}, 32'd0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
